// File: rtl/phase_ctrl_if.sv
// Instruction-memory fetch handshake between phase_ctrl and memory.
// imem_req: fetch request; imem_ack: done, imem_rdata valid same cycle.
interface phase_ctrl_if;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    modport master (
        output imem_req,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/phase_ctrl.sv
// Four-phase fetch/decode/exec/writeback sequencer with illegal-op halt.
// Ports: CLK, RSTN (async low), imem (fetch handshake), alu_q, sr1_zero,
// ph (one-hot phase), ir, pc, rf_we, halted; step only when STEP_EN defined.
module phase_ctrl (
    input  logic                CLK,
    input  logic                RSTN,
    phase_ctrl_if.master        imem,
    input  logic [15:0]         alu_q,
    input  logic                sr1_zero,
`ifdef STEP_EN
    input  logic                step,
`endif
    output logic [3:0]          ph,
    output logic [15:0]         ir,
    output logic [15:0]         pc,
    output logic                rf_we,
    output logic                halted
);

    localparam logic [3:0] PH0 = 4'b0001;
    localparam logic [3:0] PH1 = 4'b0010;
    localparam logic [3:0] PH2 = 4'b0100;
    localparam logic [3:0] PH3 = 4'b1000;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_LI  = 4'h2;
    localparam logic [3:0] OP_B   = 4'h3;
    localparam logic [3:0] OP_BNZ = 4'h4;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        req;
    logic        fetch_ok;

    logic [3:0]  op;
    logic        legal;
    logic        is_wr;
    logic        take;

    assign op    = ir_q[15:12];
    assign legal = (op == OP_ADD) || (op == OP_LI) ||
                   (op == OP_B)   || (op == OP_BNZ);
    assign is_wr = (op == OP_ADD) || (op == OP_LI);
    assign take  = (op == OP_B) || ((op == OP_BNZ) && !sr1_zero);

`ifdef STEP_EN
    // go_q: a step pulse has been seen and not yet spent on a fetch.
    logic go_q, go_d;

    assign fetch_ok = go_q;

    always_comb begin
        go_d = go_q;
        if (state_q == S_FETCH && go_q && imem.imem_ack) begin
            go_d = 1'b0;
        end else if (step && state_q != S_HALT) begin
            go_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            go_q <= 1'b0;
        end else begin
            go_q <= go_d;
        end
    end
`else
    assign fetch_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        req     = 1'b0;
        ph      = PH0;
        rf_we   = 1'b0;
        halted  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                ph  = PH0;
                req = fetch_ok;
                if (fetch_ok && imem.imem_ack) begin
                    ir_d    = imem.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ph      = PH1;
                state_d = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                ph      = PH2;
                state_d = S_WB;
            end
            S_WB: begin
                ph      = PH3;
                rf_we   = is_wr;
                pc_d    = take ? alu_q : pc_q + 16'd1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                ph     = 4'b0000;
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_FETCH;
            pc_q    <= 16'h0000;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Request is gated by reset so nothing is fetched while held in reset.
    assign imem.imem_req = req & RSTN;
    assign ir            = ir_q;
    assign pc            = pc_q;

endmodule

// File: doc/phase_ctrl.md
PHASE_CTRL -- requirements
Module: phase_ctrl

Interface
REQ-001 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port imem_req  output  1  instruction fetch request.
REQ-004 SHALL have port imem_ack  input  1  fetch complete; imem_rdata valid in same cycle.
REQ-005 SHALL have port imem_rdata  input  16  fetched instruction word.
REQ-006 SHALL have port alu_q  input  16  ALU result register (branch target or write data).
REQ-007 SHALL have port sr1_zero  input  1  high when source register 1 equals 0.
REQ-008 SHALL have port ph  output  4  one-hot phase to ALU/datapath: `PH0..`PH3 from defines.h, 4'b0000 when halted.
REQ-009 SHALL have port ir  output  16  current instruction register.
REQ-010 SHALL have port pc  output  16  program counter, word-addressed.
REQ-011 SHALL have port rf_we  output  1  register-file write strobe, one cycle.
REQ-012 SHALL have port halted  output  1  illegal-instruction halt indicator.
REQ-013 SHALL have port step  input  1  single-step pulse, present only under STEP_EN.

Function
REQ-014 SHALL implement states FETCH(ph=`PH0), DECODE(`PH1), EXEC(`PH2), WB(`PH3), HALT(ph=0).
REQ-015 FETCH SHALL assert imem_req combinationally and stay in FETCH until imem_ack=1.
REQ-016 On FETCH with imem_ack=1, ir SHALL load imem_rdata and state SHALL go to DECODE next cycle.
REQ-017 imem_ack outside FETCH SHALL be ignored; ir SHALL not change.
REQ-018 DECODE SHALL match ir against `ADD, `LI, `B, `BNZ; match -> EXEC, no match -> HALT.
REQ-019 EXEC SHALL last exactly one cycle (ALU registers alu_q at end of `PH2), then go to WB.
REQ-020 In WB, rf_we SHALL be 1 for `ADD and `LI, 0 otherwise; rf_we SHALL be 0 in every other state.
REQ-021 In WB, pc SHALL load alu_q for `B, and for `BNZ when sr1_zero=0; otherwise pc SHALL load pc+1.
REQ-022 pc+1 SHALL wrap modulo 2^16 (16'hFFFF -> 16'h0000); alu_q target SHALL be used unmodified.
REQ-023 sr1_zero SHALL be sampled only in WB.
REQ-024 WB SHALL go to FETCH next cycle; fetch-to-fetch minimum latency SHALL be 4 cycles with ack in first cycle.
REQ-025 HALT SHALL assert halted=1, imem_req=0, rf_we=0, hold pc and ir, and exit only by reset.

Reset
REQ-026 RSTN=0 SHALL asynchronously force state=FETCH, pc=0, ir=0, halted=0.
REQ-027 During reset ph SHALL read `PH0, imem_req SHALL be 0, rf_we SHALL be 0.
REQ-028 Reset mid-instruction (any state, incl. pending fetch) SHALL abandon it with no rf_we or pc update.
REQ-029 First imem_req SHALL assert in the first cycle after RSTN deasserts.

Configuration
REQ-030 Macro STEP_EN SHALL, when defined, add the step port and hold FETCH with imem_req=0 until step=1 is sampled, then request normally.
REQ-031 A step pulse arriving in DECODE/EXEC/WB SHALL be latched once and consumed at next FETCH; extra pulses before consumption SHALL be dropped.
REQ-032 Without STEP_EN, the step port SHALL not exist and FETCH SHALL request immediately.

Verification
REQ-033 Reset, then imem_ack=1 in cycle 1 with `LI word -> ph sequence PH0,PH1,PH2,PH3, rf_we=1 only in PH3, pc 0->1.
REQ-034 `B fetched at pc=16'h0010, alu_q=16'h000C -> pc=16'h000C after WB, rf_we=0.
REQ-035 `BNZ at pc=5 with sr1_zero=1 -> pc=6; repeat with sr1_zero=0, alu_q=16'h0020 -> pc=16'h0020.
REQ-036 imem_ack held low 3 cycles in FETCH -> imem_req high 3+1 cycles, ph stays `PH0, ir unchanged until ack.
REQ-037 Illegal word (matches no opcode) -> HALT: halted=1, ph=0, no further imem_req; RSTN pulse -> pc=0, FETCH.
REQ-038 pc=16'hFFFF executing `ADD -> pc=16'h0000; RSTN asserted in EXEC -> no rf_we, pc=0.
